// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with a runtime-reloadable pattern and per-cycle overlap select.
// Optional saturating match counter is enabled by defining SEQDET_MATCH_COUNT_EN.
module seq_detector_param #(
    parameter int unsigned       PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PAT_RST = PAT_W'(4'b0110),
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_nx;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    // Next window and hit qualification; load and reset both mask the hit.
    always_comb begin
        hist_nx  = {hist[PAT_W-2:0], x};
        fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit      = x_valid && !load && (fill_inc == FILL_FULL) && (hist_nx == pat_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= PAT_RST;
            hist  <= '0;
            fill  <= '0;
            z     <= 1'b0;
        end else if (load) begin
            pat_q <= pattern;
            hist  <= '0;
            fill  <= '0;
            z     <= 1'b0;
        end else if (x_valid) begin
            hist <= hist_nx;
            // Non-overlapping mode discards the matched window so no bit is reused.
            fill <= (hit && !overlap) ? '0 : fill_inc;
            z    <= hit;
        end else begin
            z <= 1'b0;
        end
    end

`ifdef SEQDET_MATCH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;

    // Saturating detection counter; reset is the only clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlap modes, gaps, reload, reset/load suppression, saturation.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic       x_valid;
    logic       load;
    logic [3:0] pattern;
    logic       overlap;
    logic       z8;
    logic       z2;
    logic [7:0] count8;
    logic [1:0] count2;

    int n_checks = 0;
    int n_errors = 0;
    int z_pulses = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .PAT_RST(4'b0110), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .load(load),
        .pattern(pattern), .overlap(overlap), .z(z8), .match_count(count8)
    );

    seq_detector_param #(.PAT_W(4), .PAT_RST(4'b0110), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .load(load),
        .pattern(pattern), .overlap(overlap), .z(z2), .match_count(count2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected counter value depends on whether the counter is built.
    function automatic int cexp(input int n);
`ifdef SEQDET_MATCH_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // One clock: drive inputs, take the edge, settle.
    task automatic step(input logic xv, input logic xb, input logic ld, input logic rs);
        x_valid = xv;
        x       = xb;
        load    = ld;
        reset   = rs;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        load    = 1'b0;
        reset   = 1'b0;
    endtask

    // Feed n valid bits MSB first, checking z after each one.
    task automatic feed(input string tag, input logic [31:0] bits, input int n, input logic [31:0] zexp);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            check($sformatf("%s z bit%0d", tag, n - i), int'(z8), int'(zexp[i]));
            if (z8) z_pulses++;
        end
    endtask

    initial begin
        reset = 1'b1; x = 1'b0; x_valid = 1'b0; load = 1'b0;
        pattern = 4'b0110; overlap = 1'b1;

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset z", int'(z8), 0);
        check("reset count", int'(count8), 0);

        overlap = 1'b1;
        feed("ovl1 0110110", 32'b0110110, 7, 32'b0001001);
        check("ovl1 count", int'(count8), cexp(2));

        step(1'b0, 1'b0, 1'b0, 1'b1);
        overlap = 1'b0;
        feed("ovl0 0110110", 32'b0110110, 7, 32'b0001000);
        check("ovl0 count", int'(count8), cexp(1));

        step(1'b0, 1'b0, 1'b0, 1'b1);
        feed("gap head", 32'b01, 2, 32'b00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check("gap idle z", int'(z8), 0);
        end
        feed("gap tail", 32'b10, 2, 32'b01);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("gap single pulse", int'(z8), 0);
        check("gap count", int'(count8), cexp(1));

        pattern = 4'b1111;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("load z", int'(z8), 0);
        check("load count held", int'(count8), cexp(1));
        overlap = 1'b1;
        feed("ones ovl1", 32'b1111111, 7, 32'b0001111);
        check("ones ovl1 count", int'(count8), cexp(5));
        check("sat after ones", int'(count2), cexp(3));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        overlap = 1'b0;
        feed("ones ovl0", 32'b1111111, 7, 32'b0001000);
        check("ones ovl0 count", int'(count8), cexp(6));

        pattern = 4'b0110;
        overlap = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        feed("ldcut head", 32'b011, 3, 32'b000);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("ldcut z", int'(z8), 0);
        check("ldcut count", int'(count8), cexp(6));
        feed("after ldcut", 32'b0110, 4, 32'b0001);
        check("after ldcut count", int'(count8), cexp(7));

        feed("rstcut head", 32'b011, 3, 32'b000);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("rstcut z", int'(z8), 0);
        check("rstcut count", int'(count8), 0);

        pattern = 4'b1111;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pattern = 4'b0110;
        feed("rst over load 1111", 32'b1111, 4, 32'b0000);
        feed("rst over load 0110", 32'b0110, 4, 32'b0001);
        check("rst over load count", int'(count8), cexp(1));

        step(1'b0, 1'b0, 1'b0, 1'b1);
        overlap = 1'b1;
        z_pulses = 0;
        feed("sat stream", 32'b0110110110110110, 16, 32'b0001001001001001);
        check("sat pulses", z_pulses, 5);
        check("sat count2", int'(count2), cexp(3));
        check("sat count8", int'(count8), cexp(5));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat z idle", int'(z2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
